// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the ALU arbiter slice.
package alu_arb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NOPS_DEFAULT = 6;

  // ALU control codes; 110/111 are unused and evaluate to zero.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5
  } alu_op_e;

  // Output slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational integer ALU with zero flag.
module alu
  import alu_arb_pkg::*;
#(
  parameter int XLen    = XLEN_DEFAULT,
  parameter int OpWidth = 3
) (
  input  logic [XLen-1:0]    a_i,
  input  logic [XLen-1:0]    b_i,
  input  logic [OpWidth-1:0] op_i,
  output logic [XLen-1:0]    result_o,
  output logic               zero_o
);

  logic [2:0] op_code;

  // Decode the control code and compute the result; unknown codes give zero.
  always_comb begin
    op_code  = 3'(op_i);
    result_o = {XLen{1'b0}};
    case (op_code)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLT:  result_o = {{(XLen-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = {XLen{1'b0}};
    endcase
    zero_o = (result_o == {XLen{1'b0}});
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int NReq    = 2,
  localparam int IdWidth = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NReq-1:0]    req_i,
  input  logic               en_i,
  output logic [NReq-1:0]    gnt_o,
  output logic [IdWidth-1:0] gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [IdWidth-1:0] rr_ptr;
  logic [IdWidth-1:0] rr_ptr_nxt;
  int                 idx;

  // Search upward from rr_ptr for the first valid request when enabled.
  always_comb begin
    gnt_o       = {NReq{1'b0}};
    gnt_idx_o   = {IdWidth{1'b0}};
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int off = 0; off < NReq; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NReq) begin
        idx = idx - NReq;
      end else begin
        idx = idx;
      end
      if (en_i && !gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdWidth'(idx);
        gnt_o[idx]  = 1'b1;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping at NReq.
  always_comb begin
    if (gnt_idx_o == IdWidth'(NReq - 1)) begin
      rr_ptr_nxt = {IdWidth{1'b0}};
    end else begin
      rr_ptr_nxt = gnt_idx_o + IdWidth'(1);
    end
  end

  // Round-robin pointer register; advances only when a grant is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= {IdWidth{1'b0}};
    end else if (gnt_valid_o) begin
      rr_ptr <= rr_ptr_nxt;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NReq requesters; results held in one output slot.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int XLen      = XLEN_DEFAULT,
  parameter  int NOps      = NOPS_DEFAULT,
  parameter  int NReq      = 2,
  localparam int NOpsWidth = $clog2(NOps),
  localparam int IdWidth   = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NReq-1:0]           req_valid_i,
  output logic [NReq-1:0]           req_ready_o,
  input  logic [NReq*XLen-1:0]      req_a_i,
  input  logic [NReq*XLen-1:0]      req_b_i,
  input  logic [NReq*NOpsWidth-1:0] req_op_i,
  output logic [NReq-1:0]           rsp_valid_o,
  input  logic [NReq-1:0]           rsp_ready_i,
  output logic [XLen-1:0]           rsp_result_o,
  output logic                      rsp_zero_o
);

  slot_state_e            state_r;
  slot_state_e            state_nxt;
  logic [NReq-1:0]        rsp_valid_r;
  logic [XLen-1:0]        result_r;
  logic                   zero_r;

  logic                   drain;
  logic                   free;
  logic                   arb_en;
  logic [NReq-1:0]        gnt;
  logic [IdWidth-1:0]     gnt_idx;
  logic                   grant;
  logic [XLen-1:0]        a_sel;
  logic [XLen-1:0]        b_sel;
  logic [NOpsWidth-1:0]   op_sel;
  logic [XLen-1:0]        alu_result;
  logic                   alu_zero;

  // Slot frees up when empty or when its owner accepts in this cycle.
  always_comb begin
    drain  = (state_r == SLOT_FULL) && (|(rsp_valid_r & rsp_ready_i));
    free   = (state_r == SLOT_EMPTY) || drain;
    arb_en = free && !rst_i;
  end

  rr_arbiter #(
    .NReq (NReq)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_valid_i),
    .en_i        (arb_en),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (grant)
  );

  assign req_ready_o = gnt;

  // Route the granted requester's operands and op code to the ALU.
  always_comb begin
    a_sel  = req_a_i[int'(gnt_idx)*XLen +: XLen];
    b_sel  = req_b_i[int'(gnt_idx)*XLen +: XLen];
    op_sel = req_op_i[int'(gnt_idx)*NOpsWidth +: NOpsWidth];
  end

  alu #(
    .XLen    (XLen),
    .OpWidth (NOpsWidth)
  ) u_alu (
    .a_i      (a_sel),
    .b_i      (b_sel),
    .op_i     (op_sel),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Slot next state: a grant always refills; a drain alone empties it.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (grant) begin
          state_nxt = SLOT_FULL;
        end else begin
          state_nxt = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (grant) begin
          state_nxt = SLOT_FULL;
        end else if (drain) begin
          state_nxt = SLOT_EMPTY;
        end else begin
          state_nxt = SLOT_FULL;
        end
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Slot contents: load on grant, clear valid on drain, otherwise hold stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_r <= {NReq{1'b0}};
      result_r    <= {XLen{1'b0}};
      zero_r      <= 1'b0;
    end else if (grant) begin
      rsp_valid_r <= gnt;
      result_r    <= alu_result;
      zero_r      <= alu_zero;
    end else if (drain) begin
      rsp_valid_r <= {NReq{1'b0}};
      result_r    <= result_r;
      zero_r      <= zero_r;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      result_r    <= result_r;
      zero_r      <= zero_r;
    end
  end

  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_result_o = result_r;
  assign rsp_zero_o   = zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an expected-response scoreboard.
module tb_alu_arbiter;

  localparam int XLen = 32;
  localparam int NReq = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] a_v [2];
  logic [31:0] b_v [2];
  logic [2:0]  op_v [2];
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   ptr_m  = 0;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  assign req_a  = {a_v[1], a_v[0]};
  assign req_b  = {b_v[1], b_v[0]};
  assign req_op = {op_v[1], op_v[0]};

  alu_arbiter #(.XLen(XLen), .NOps(6), .NReq(NReq)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs at negedge, then advance the model at posedge.
  task automatic step(input string tag);
    logic [1:0] exp_rdy;
    logic       drain;
    logic       free;
    int         g;
    exp_t       e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(1) << exp_q[0].owner);
      check({tag, "/rsp_result"}, rsp_result, exp_q[0].res);
      check({tag, "/rsp_zero"}, 32'(rsp_zero), 32'(exp_q[0].zero));
      drain = rsp_ready[exp_q[0].owner];
    end else begin
      check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
      drain = 1'b0;
    end
    free = (exp_q.size() == 0) || drain;
    g = -1;
    if (free) begin
      for (int i = 0; i < NReq; i++) begin
        int k;
        k = (ptr_m + i) % NReq;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
    check({tag, "/req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (drain) e = exp_q.pop_front();
    if (g >= 0) begin
      e.owner = g;
      e.res   = ref_alu(op_v[g], a_v[g], b_v[g]);
      e.zero  = (e.res == 32'd0);
      exp_q.push_back(e);
      ptr_m = (g + 1) % NReq;
    end
    #1;
  endtask

  // Reset for one cycle with current inputs held, then confirm the idle state.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "/ready_in_reset"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    ptr_m = 0;
    @(negedge clk);
    check({tag, "/valid_after"}, 32'(rsp_valid), 32'd0);
    check({tag, "/result_after"}, rsp_result, 32'd0);
    check({tag, "/zero_after"}, 32'(rsp_zero), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_v[0] = 32'd0; a_v[1] = 32'd0;
    b_v[0] = 32'd0; b_v[1] = 32'd0;
    op_v[0] = 3'd0; op_v[1] = 3'd0;

    // Reset then a single ADD on requester 0.
    do_reset("init");
    a_v[0] = 32'd5; b_v[0] = 32'd7; op_v[0] = 3'd0;
    req_valid = 2'b01; rsp_ready = 2'b01;
    step("add_grant");
    req_valid = 2'b00;
    check("add_result", rsp_result, 32'd12);
    check("add_zero", 32'(rsp_zero), 32'd0);
    check("add_valid", 32'(rsp_valid), 32'd1);
    step("add_rsp");
    step("add_idle");

    // Contention from reset: expect alternating grants 0,1,0,1.
    do_reset("cont");
    a_v[0] = 32'd3; b_v[0] = 32'd3; op_v[0] = 3'd1;
    a_v[1] = 32'hFFFF_FFFF; b_v[1] = 32'd1; op_v[1] = 3'd5;
    req_valid = 2'b11; rsp_ready = 2'b11;
    step("cont0");
    check("cont0_owner", 32'(rsp_valid), 32'd1);
    check("cont0_zero", 32'(rsp_zero), 32'd1);
    step("cont1");
    check("cont1_owner", 32'(rsp_valid), 32'd2);
    check("cont1_result", rsp_result, 32'd1);
    step("cont2");
    step("cont3");
    req_valid = 2'b00;
    step("cont_drain");
    step("cont_idle");

    // Backpressure: XOR result held while requester 1 waits.
    a_v[0] = 32'h0000_00FF; b_v[0] = 32'h0000_000F; op_v[0] = 3'd4;
    a_v[1] = 32'd2; b_v[1] = 32'd3; op_v[1] = 3'd0;
    req_valid = 2'b01; rsp_ready = 2'b00;
    step("bp_grant");
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step("bp_stall");
      check("bp_held", rsp_result, 32'h0000_00F0);
    end
    rsp_ready = 2'b01;
    step("bp_drain_grant");
    req_valid = 2'b00; rsp_ready = 2'b10;
    check("bp_req1_result", rsp_result, 32'd5);
    step("bp_rsp1");
    step("bp_idle");

    // Back-to-back stream from requester 1.
    req_valid = 2'b10; rsp_ready = 2'b10;
    a_v[1] = 32'h0000_F0F0; b_v[1] = 32'h0000_FF00; op_v[1] = 3'd2;
    step("b2b_and");
    op_v[1] = 3'd3;
    step("b2b_or");
    op_v[1] = 3'd0;
    step("b2b_add");
    req_valid = 2'b00;
    check("b2b_add_result", rsp_result, 32'h0001_EFF0);
    step("b2b_last");
    step("b2b_idle");

    // Unused op code 111 is accepted and yields zero.
    a_v[0] = 32'd1; b_v[0] = 32'd1; op_v[0] = 3'd7;
    req_valid = 2'b01; rsp_ready = 2'b01;
    step("ill_grant");
    req_valid = 2'b00;
    check("ill_result", rsp_result, 32'd0);
    check("ill_zero", 32'(rsp_zero), 32'd1);
    step("ill_rsp");

    // Reset while holding 9: result discarded, pointer back to 0.
    a_v[0] = 32'd4; b_v[0] = 32'd5; op_v[0] = 3'd0;
    req_valid = 2'b01; rsp_ready = 2'b00;
    step("r9_grant");
    req_valid = 2'b00;
    step("r9_hold");
    check("r9_value", rsp_result, 32'd9);
    req_valid = 2'b10; rsp_ready = 2'b01;
    do_reset("midrst");
    a_v[1] = 32'd6; b_v[1] = 32'd6; op_v[1] = 3'd1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    step("post_rst_grant");
    check("post_rst_owner", 32'(rsp_valid), 32'd1);
    req_valid = 2'b00;
    step("post_rst_rsp");
    step("post_rst_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between `NReq` requesters, such as decode ports or a multi-cycle unit, using round-robin arbitration and valid/ready handshakes. Each accepted operation is evaluated in the cycle it is granted. The result is held in a single output register until the owning requester accepts it. Sits between the issue logic and the integer datapath.

## Interface
- `XLen`, 32, operand/result width
- `NOps`, 6, number of ALU operations; `NOpsWidth = $clog2(NOps)` (localparam)
- `NReq`, 2, number of requesters (2..8); `IdWidth = $clog2(NReq)` (localparam)

Ports (clock and reset first):
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `req_valid_i`  in  NReq  per-requester operation valid
- `req_ready_o`  out  NReq  per-requester grant; one-hot or zero
- `req_a_i`  in  NReq*XLen  packed operand A, requester k at `[k*XLen +: XLen]`
- `req_b_i`  in  NReq*XLen  packed operand B, same packing
- `req_op_i`  in  NReq*NOpsWidth  packed ALU control code
- `rsp_valid_o`  out  NReq  one-hot response valid, bit = owner
- `rsp_ready_i`  in  NReq  per-requester response accept
- `rsp_result_o`  out  XLen  registered ALU result, shared bus
- `rsp_zero_o`  out  1  registered zero flag of that result

## Operation
- ALU op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed). 110/111 give result 0 with zero=1 and are accepted normally; no error is raised.
- Output slot FSM has two states:
  - EMPTY: `rsp_valid_o`=0.
  - FULL: slot holds owner, result and zero.
- `drain` = FULL & `rsp_ready_i[owner]`.
- `free` = EMPTY | `drain`.
- When `free` and any `req_valid_i` bit is set, exactly one request g is granted: `req_ready_o[g]`=1. All other ready bits are 0, and all are 0 when not `free`.
- Grant g is the first valid index searching upward from `rr_ptr`, wrapping NReq-1 → 0.
- On grant:
  - `rr_ptr` ← (g+1) mod NReq.
  - The slot loads owner g, `alu(a_g, b_g, op_g)` result and zero.
  - The slot is FULL next cycle.
- Drain without a grant: slot goes FULL → EMPTY.
- Drain with a grant in the same cycle: the slot stays FULL with the new contents, with no bubble.
- `rr_ptr` changes only on a grant.
- Requester rules:
  - Once `req_valid_i[k]` is asserted, it must stay high with stable a/b/op until `req_ready_o[k]`.
  - Valid must not depend on ready.
- Response side: the slot contents are stable while FULL and not drained. `rsp_ready_i` bits of non-owners are ignored.
- `req_ready_o` depends combinationally on `req_valid_i`, `rsp_ready_i` and state only. `rsp_*` outputs are purely registered.

## Timing
- Reset values:
  - Slot EMPTY, `rr_ptr`=0.
  - `rsp_valid_o`=0, `rsp_result_o`=0, `rsp_zero_o`=0.
  - `req_ready_o`=0 during the reset cycle.
- Latency: request accepted in cycle n → `rsp_valid_o[g]` high in cycle n+1.
- Throughput: one operation per cycle when owners keep `rsp_ready_i` high.
- Reset mid-operation: a held result is discarded without being delivered. A request presented in the reset cycle is not accepted.
- Stall: while FULL and not drained, all `req_ready_o`=0 and pending requests wait.

## Structure
- Package `alu_arb_pkg`:
  - `alu_op_e` enum for the six codes.
  - `slot_state_e` enum {`SLOT_EMPTY`, `SLOT_FULL`}.
  - Default widths for `XLen`/`NOps`.
- Sub-module `rr_arbiter` (parameter `NReq`):
  - Inputs: request vector, enable (`free`).
  - Outputs: one-hot grant and binary index.
  - Owns `rr_ptr`, with synchronous reset.
- The top level does the operand mux by grant index, instantiates `alu`, and holds the slot registers.

## Test plan
- Reset, then single op: requester 0 ADD a=5, b=7 → `req_ready_o`=01 the same cycle; next cycle `rsp_valid_o`=01, result 12, zero=0.
- Contention: both valid from reset, SUB 3-3 on req0 and SLT -1<1 on req1, `rsp_ready_i`=11 → grant order 0,1,0,1. Responses are result 0/zero=1 (owner 0), then 1/zero=0 (owner 1).
- Backpressure: req0 XOR 0xFF^0x0F with `rsp_ready_i`=00 for 3 cycles → `rsp_result_o`=0xF0 held, `req_ready_o`=00 while req1 waits. On ready, drain and grant of req1 occur in the same cycle.
- Back-to-back: req1 streams AND/OR/ADD each cycle with `rsp_ready_i[1]`=1 → three responses in consecutive cycles with no bubbles.
- Illegal op 111 with a=1, b=1 → accepted, result 0, zero=1.
- Reset while FULL holding result 9 → next cycle `rsp_valid_o`=0, `rsp_result_o`=0, `rr_ptr`=0, and the old result is never delivered.
